// File: rtl/mips_pkg.sv
// Shared types and constants for the multicycle MIPS controller.
package mips_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, REX, RWB, IEX, IWB, BEQ, BNE, JMP
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_FUNCT = 3'b010;
  localparam logic [2:0] ALUOP_OR    = 3'b011;
  localparam logic [2:0] ALUOP_AND   = 3'b100;
  localparam logic [2:0] ALUOP_SLT   = 3'b101;

  // Raw control word for one state. mem_gate marks strobes that must wait
  // for the memory port (instruction fetch); branch/branchne feed pcen.
  typedef struct packed {
    logic       iord;
    logic       irwrite;
    logic       memwrite;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       extop;
    logic [2:0] aluop;
    logic [1:0] pcsrc;
    logic       pcwrite;
    logic       mem_gate;
    logic       branch;
    logic       branchne;
    logic       illegal_op;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  // True for every opcode the core executes.
  function automatic logic op_known(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE,
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_J: return 1'b1;
      default:                                 return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Combinational decode of controller state (plus opcode where needed) into
// the raw multicycle control word.
module mc_ctrl_outdec
  import mips_pkg::*;
(
  input  logic [3:0]        state,
  input  logic [5:0]        op,
  output logic [CTRL_W-1:0] ctrl
);

  ctrl_t c;

  assign ctrl = c;

  // Moore decode: every field defaults to 0, each state sets only its own.
  always_comb begin
    c = '0;
    case (state_t'(state))
      FETCH: begin
        c.irwrite  = 1'b1;
        c.alusrcb  = 2'b01;
        c.aluop    = ALUOP_ADD;
        c.pcsrc    = 2'b00;
        c.pcwrite  = 1'b1;
        c.mem_gate = 1'b1;
      end
      DECODE: begin
        c.alusrcb    = 2'b11;
        c.aluop      = ALUOP_ADD;
        c.illegal_op = ~op_known(op);
      end
      MEMADR: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
        c.aluop   = ALUOP_ADD;
      end
      MEMRD: c.iord = 1'b1;
      MEMWB: begin
        c.memtoreg = 1'b1;
        c.regwrite = 1'b1;
      end
      MEMWR: begin
        c.iord     = 1'b1;
        c.memwrite = 1'b1;
      end
      REX: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b00;
        c.aluop   = ALUOP_FUNCT;
      end
      RWB: begin
        c.regdst   = 1'b1;
        c.regwrite = 1'b1;
      end
      IEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
        case (op)
          OP_ANDI: begin c.aluop = ALUOP_AND; c.extop = 1'b1; end
          OP_ORI:  begin c.aluop = ALUOP_OR;  c.extop = 1'b1; end
          OP_SLTI: c.aluop = ALUOP_SLT;
          default: c.aluop = ALUOP_ADD;
        endcase
      end
      IWB: c.regwrite = 1'b1;
      BEQ, BNE: begin
        c.alusrca  = 1'b1;
        c.alusrcb  = 2'b00;
        c.aluop    = ALUOP_SUB;
        c.pcsrc    = 2'b01;
        c.branch   = (state_t'(state) == BEQ);
        c.branchne = (state_t'(state) == BNE);
      end
      JMP: begin
        c.pcsrc   = 2'b10;
        c.pcwrite = 1'b1;
      end
      default: c = '0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Main controller for the multicycle MIPS core: state register, next-state
// sequencing and the PC-load / write-enable gating.
module mc_ctrl_fsm
  import mips_pkg::*;
#(
  parameter int WAIT_EN = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       iord,
  output logic       irwrite,
  output logic       memwrite,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       extop,
  output logic [2:0] aluop,
  output logic [1:0] pcsrc,
  output logic       pcen,
  output logic       illegal_op
);

  localparam logic WAIT_ON = (WAIT_EN != 0);

  state_t            state;
  state_t            state_next;
  logic              mem_ok;
  logic [CTRL_W-1:0] ctrl_bits;
  ctrl_t             c;

  // With waiting disabled the memory is treated as always ready.
  assign mem_ok = mem_ready | ~WAIT_ON;

  // State register; reset aborts any instruction in flight.
  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_next;
  end

  // Next-state sequencing; unknown encodings fall back to FETCH.
  always_comb begin
    state_next = FETCH;
    case (state)
      FETCH:  state_next = mem_ok ? DECODE : FETCH;
      DECODE: begin
        case (op)
          OP_LW, OP_SW:                       state_next = MEMADR;
          OP_RTYPE:                           state_next = REX;
          OP_BEQ:                             state_next = BEQ;
          OP_BNE:                             state_next = BNE;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI:  state_next = IEX;
          OP_J:                               state_next = JMP;
          default:                            state_next = FETCH;
        endcase
      end
      MEMADR: state_next = (op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:  state_next = mem_ok ? MEMWB : MEMRD;
      MEMWR:  state_next = mem_ok ? FETCH : MEMWR;
      REX:    state_next = RWB;
      IEX:    state_next = IWB;
      default: state_next = FETCH;
    endcase
  end

  mc_ctrl_outdec u_outdec (
    .state (state),
    .op    (op),
    .ctrl  (ctrl_bits)
  );

  assign c = ctrl_bits;

  assign iord       = c.iord;
  assign regdst     = c.regdst;
  assign memtoreg   = c.memtoreg;
  assign alusrca    = c.alusrca;
  assign alusrcb    = c.alusrcb;
  assign extop      = c.extop;
  assign aluop      = c.aluop;
  assign pcsrc      = c.pcsrc;
  assign illegal_op = c.illegal_op;

  // Enables are suppressed while reset is high so an aborted store or
  // register write never lands; fetch strobes also wait on memory.
  assign irwrite  = c.irwrite & mem_ok & ~reset;
  assign memwrite = c.memwrite & ~reset;
  assign regwrite = c.regwrite & ~reset;
  assign pcen     = ((c.pcwrite & (mem_ok | ~c.mem_gate))
                    | (c.branch & zero)
                    | (c.branchne & ~zero)) & ~reset;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: one instance without memory waits, one with.
module tb_mc_ctrl_fsm;

  logic       clk       = 1'b0;
  logic       reset     = 1'b1;
  logic [5:0] op        = 6'd0;
  logic       zero      = 1'b0;
  logic       mem_ready = 1'b1;

  // Output word: [16]iord [15]irwrite [14]memwrite [13]regwrite [12]regdst
  // [11]memtoreg [10]alusrca [9:8]alusrcb [7]extop [6:4]aluop [3:2]pcsrc
  // [1]pcen [0]illegal_op
  wire [16:0] w0;
  wire [16:0] w1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mc_ctrl_fsm #(.WAIT_EN(0)) dut0 (
    .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
    .iord(w0[16]), .irwrite(w0[15]), .memwrite(w0[14]), .regwrite(w0[13]),
    .regdst(w0[12]), .memtoreg(w0[11]), .alusrca(w0[10]), .alusrcb(w0[9:8]),
    .extop(w0[7]), .aluop(w0[6:4]), .pcsrc(w0[3:2]), .pcen(w0[1]),
    .illegal_op(w0[0])
  );

  mc_ctrl_fsm #(.WAIT_EN(1)) dut1 (
    .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
    .iord(w1[16]), .irwrite(w1[15]), .memwrite(w1[14]), .regwrite(w1[13]),
    .regdst(w1[12]), .memtoreg(w1[11]), .alusrca(w1[10]), .alusrcb(w1[9:8]),
    .extop(w1[7]), .aluop(w1[6:4]), .pcsrc(w1[3:2]), .pcen(w1[1]),
    .illegal_op(w1[0])
  );

  // ---------------- reference model ----------------
  // An instruction is a class plus a cycle position: position 0 is fetch,
  // 1 is decode, and the class fixes how many further cycles follow.
  localparam int K_LW = 0, K_SW = 1, K_R = 2, K_I = 3, K_BEQ = 4, K_BNE = 5,
                 K_J = 6, K_ILL = 7;

  function automatic int classify(input logic [5:0] o);
    case (o)
      6'b100011: return K_LW;
      6'b101011: return K_SW;
      6'b000000: return K_R;
      6'b001000, 6'b001100, 6'b001101, 6'b001010: return K_I;
      6'b000100: return K_BEQ;
      6'b000101: return K_BNE;
      6'b000010: return K_J;
      default:   return K_ILL;
    endcase
  endfunction

  // Last position index = cycles per instruction - 1.
  function automatic int last_pos(input int k);
    case (k)
      K_LW:            return 4;
      K_SW, K_R, K_I:  return 3;
      K_ILL:           return 1;
      default:         return 2;
    endcase
  endfunction

  function automatic logic [16:0] exp_out(input int k, input int p,
                                          input logic [5:0] o, input logic z,
                                          input logic ok, input logic rs);
    logic       iord_e, irw_e, mw_e, rw_e, rd_e, m2r_e, sa_e, ext_e, pcen_e, ill_e;
    logic [1:0] sb_e, pcs_e;
    logic [2:0] alu_e;
    iord_e = 0; irw_e = 0; mw_e = 0; rw_e = 0; rd_e = 0; m2r_e = 0; sa_e = 0;
    ext_e = 0; pcen_e = 0; ill_e = 0; sb_e = 2'b00; pcs_e = 2'b00; alu_e = 3'b000;
    if (p == 0) begin
      sb_e = 2'b01; irw_e = ok; pcen_e = ok;
    end else if (p == 1) begin
      sb_e = 2'b11; ill_e = (classify(o) == K_ILL);
    end else begin
      case (k)
        K_LW, K_SW: begin
          if (p == 2) begin sa_e = 1; sb_e = 2'b10; end
          else if (k == K_SW) begin iord_e = 1; mw_e = 1; end
          else if (p == 3) iord_e = 1;
          else begin m2r_e = 1; rw_e = 1; end
        end
        K_R: begin
          if (p == 2) begin sa_e = 1; alu_e = 3'b010; end
          else begin rd_e = 1; rw_e = 1; end
        end
        K_I: begin
          if (p == 2) begin
            sa_e = 1; sb_e = 2'b10;
            if (o == 6'b001100) begin alu_e = 3'b100; ext_e = 1; end
            else if (o == 6'b001101) begin alu_e = 3'b011; ext_e = 1; end
            else if (o == 6'b001010) alu_e = 3'b101;
          end else rw_e = 1;
        end
        K_BEQ, K_BNE: begin
          sa_e = 1; alu_e = 3'b001; pcs_e = 2'b01;
          pcen_e = (k == K_BEQ) ? z : ~z;
        end
        K_J: begin pcs_e = 2'b10; pcen_e = 1; end
        default: ;
      endcase
    end
    if (rs) begin irw_e = 0; mw_e = 0; rw_e = 0; pcen_e = 0; end
    return {iord_e, irw_e, mw_e, rw_e, rd_e, m2r_e, sa_e, sb_e, ext_e, alu_e,
            pcs_e, pcen_e, ill_e};
  endfunction

  int pos_m [2];
  int kind_m [2];
  bit armed = 1'b0;

  // Advance each model instance (index 0 never waits on memory).
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (reset) pos_m[d] <= 0;
      else if (pos_m[d] == 0) begin
        if (mem_ready || d == 0) pos_m[d] <= 1;
      end else if (pos_m[d] == 1) begin
        kind_m[d] <= classify(op);
        pos_m[d]  <= (classify(op) == K_ILL) ? 0 : 2;
      end else if (pos_m[d] == 3 && (kind_m[d] == K_LW || kind_m[d] == K_SW)
                   && !(mem_ready || d == 0)) begin
        pos_m[d] <= pos_m[d];
      end else if (pos_m[d] == last_pos(kind_m[d])) pos_m[d] <= 0;
      else pos_m[d] <= pos_m[d] + 1;
    end
    if (reset) armed <= 1'b1;
  end

  // Compare both instances against the model every cycle once reset was seen.
  always @(negedge clk) begin
    if (armed) begin
      for (int d = 0; d < 2; d++) begin
        checks++;
        if ((d == 0 ? w0 : w1) !== exp_out(kind_m[d], pos_m[d], op, zero,
                                           mem_ready || d == 0, reset)) begin
          errors++;
          $display("FAIL ctl_word dut%0d t=%0t: actual %05h, expected %05h", d, $time,
                   (d == 0 ? w0 : w1),
                   exp_out(kind_m[d], pos_m[d], op, zero, mem_ready || d == 0, reset));
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic chk(input string name, input logic [16:0] act, input logic [16:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: actual %0h, expected %0h", name, act, expv);
    end
  endtask

  task automatic cyc(input logic [5:0] o, input logic z, input logic r, input logic rs);
    @(posedge clk);
    #1;
    op = o; zero = z; mem_ready = r; reset = rs;
    #3;
  endtask

  logic [5:0] t_op [8] = '{6'b000000, 6'b000100, 6'b000100, 6'b001000,
                           6'b001100, 6'b001010, 6'b101011, 6'b100011};
  logic       t_z  [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  int         t_n  [8] = '{4, 3, 3, 4, 4, 4, 4, 5};
  logic       sw_rdy [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    for (int i = 0; i < 3; i++) begin
      cyc(6'd0, 1'b0, 1'b1, 1'b1);
      chk("reset_enables_w1", {13'd0, w1[15], w1[14], w1[13], w1[1]}, 17'd0);
      chk("reset_enables_w0", {13'd0, w0[15], w0[14], w0[13], w0[1]}, 17'd0);
    end

    for (int i = 1; i <= 5; i++) begin
      cyc(6'b100011, 1'b0, 1'b1, 1'b0);
      if (i == 1) chk("lw_fetch_irwrite", w0[15], 17'd1);
      if (i == 3) chk("lw_memadr_alusrcb", w0[9:8], 17'd2);
      chk("lw_regwrite_memtoreg", {w0[13], w0[11]}, (i == 5) ? 17'd3 : 17'd0);
    end

    for (int i = 1; i <= 3; i++) begin
      cyc(6'b000101, 1'b0, 1'b1, 1'b0);
      if (i == 3) chk("bne_taken_pcen_pcsrc", {w0[1], w0[3:2]}, 17'b101);
    end
    for (int i = 1; i <= 3; i++) begin
      cyc(6'b000101, 1'b1, 1'b1, 1'b0);
      if (i >= 2) chk("bne_not_taken_pcen", w0[1], 17'd0);
    end

    for (int i = 1; i <= 4; i++) begin
      cyc(6'b001101, 1'b0, 1'b1, 1'b0);
      if (i == 3) chk("ori_iex_aluop_extop_alusrcb", {w0[6:4], w0[7], w0[9:8]}, 17'b011110);
      if (i == 4) chk("ori_iwb_regdst_regwrite", {w0[12], w0[13]}, 17'b01);
    end

    for (int i = 1; i <= 4; i++) begin
      cyc(6'b111111, 1'b0, 1'b1, 1'b0);
      if (i == 2) begin
        chk("illegal_pulse", w0[0], 17'd1);
        chk("illegal_no_writes", {w0[13], w0[14]}, 17'd0);
      end
      if (i == 3) chk("illegal_cpi2_refetch", {w0[15], w0[0]}, 17'b10);
    end

    for (int t = 0; t < 8; t++)
      for (int i = 1; i <= t_n[t]; i++) cyc(t_op[t], t_z[t], 1'b1, 1'b0);

    for (int i = 1; i <= 3; i++) begin
      cyc(6'b000010, 1'b0, 1'b1, 1'b0);
      if (i == 3) chk("j_pcsrc_pcen", {w0[3:2], w0[1]}, 17'b101);
    end

    cyc(6'd0, 1'b0, 1'b1, 1'b1);
    for (int i = 1; i <= 9; i++) begin
      cyc(6'b101011, 1'b0, sw_rdy[i-1], 1'b0);
      if (i <= 3) chk("sw_wait_fetch_irwrite", w1[15], (i == 3) ? 17'd1 : 17'd0);
      chk("sw_wait_memwrite", w1[14], (i >= 6) ? 17'd1 : 17'd0);
    end
    cyc(6'b101011, 1'b0, 1'b1, 1'b0);
    chk("sw_wait_cpi9_next_fetch", w1[15], 17'd1);

    cyc(6'd0, 1'b0, 1'b1, 1'b1);
    cyc(6'b101011, 1'b0, 1'b1, 1'b0);
    cyc(6'b101011, 1'b0, 1'b1, 1'b0);
    cyc(6'b101011, 1'b0, 1'b1, 1'b0);
    cyc(6'b101011, 1'b0, 1'b0, 1'b0);
    chk("midwr_memwrite_before_reset", {w1[16], w1[14]}, 17'b11);
    for (int i = 0; i < 3; i++) begin
      cyc(6'b101011, 1'b0, 1'b0, 1'b1);
      chk("midwr_reset_enables", {13'd0, w1[15], w1[14], w1[13], w1[1]}, 17'd0);
    end
    cyc(6'b101011, 1'b0, 1'b1, 1'b0);
    chk("after_reset_fetch", {w1[15], w1[9:8]}, 17'b101);

    cyc(6'd0, 1'b0, 1'b1, 1'b1);
    cyc(6'd0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, actual unfinished, expected finished");
    $fatal(1, "watchdog");
  end

endmodule
